controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 185 ++++++++++++++++++
 tb/tb_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// ----------------------------------------------------------------------------
// controller
// Command-driven grayscale LED driver controller. A 32-bit instruction word
// ({opcode, target, data}) is captured in IDLE and executed exactly once:
// load a channel value, clear the channel buffer, serially shift the whole
// buffer out to the driver chain followed by a latch strobe, or enable/disable
// the grayscale PWM clock.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   instruction  [31:24] opcode, [23:16] target, [15:0] data
//   serial       serial grayscale data, MSB first (ch15 first)
//   sclk         shift clock, one rising edge per bit
//   lat          one-hot latch strobe, bit selected by target[1:0]
//   gsclk        grayscale PWM clock (clk/2 while enabled)
//   state        current FSM state code
//
// state       | code | meaning
// ------------+------+------------------------------------------------------
// IDLE        |  0   | waiting for a nonzero instruction, captures it
// DECODE      |  1   | dispatch on captured opcode
// LOAD        |  2   | write data[11:0] into channel target[3:0]
// CLEAR       |  3   | zero every channel
// SHIFT_SETUP |  4   | load shift register from buffer, arm bit counter
// SHIFT_LO    |  5   | present bit, sclk low
// SHIFT_HI    |  6   | sclk high, advance to next bit
// LATCH       |  7   | one-cycle lat strobe
// GSCFG       |  8   | set gsclk enable from data[0]
// WAIT        |  9   | hold until instruction returns to zero
// ----------------------------------------------------------------------------
module controller #(
    parameter int NUM_CH   = 16,
    parameter int GS_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic        serial,
    output logic        sclk,
    output logic [3:0]  lat,
    output logic        gsclk,
    output logic [3:0]  state
);

    localparam int SHIFT_LEN = NUM_CH * GS_WIDTH;
    localparam int IDX_W     = $clog2(NUM_CH);
    localparam int CNT_W     = $clog2(SHIFT_LEN + 1);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_DECODE      = 4'd1,
        ST_LOAD        = 4'd2,
        ST_CLEAR       = 4'd3,
        ST_SHIFT_SETUP = 4'd4,
        ST_SHIFT_LO    = 4'd5,
        ST_SHIFT_HI    = 4'd6,
        ST_LATCH       = 4'd7,
        ST_GSCFG       = 4'd8,
        ST_WAIT        = 4'd9
    } state_e;

    state_e               state_q,  state_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [IDX_W-1:0]     tgt_q,    tgt_d;
    logic [GS_WIDTH-1:0]  data_q,   data_d;
    logic [GS_WIDTH-1:0]  chbuf_q [NUM_CH];
    logic [GS_WIDTH-1:0]  chbuf_d [NUM_CH];
    logic [SHIFT_LEN-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 gs_en_q,  gs_en_d;
    logic                 serial_q, serial_d;
    logic                 sclk_q,   sclk_d;
    logic [3:0]           lat_q,    lat_d;
    logic                 gsclk_q,  gsclk_d;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        tgt_d    = tgt_q;
        data_d   = data_q;
        chbuf_d  = chbuf_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        gs_en_d  = gs_en_q;

        case (state_q)
            ST_IDLE: begin
                if (instruction != '0) begin
                    // Only the fields that are ever used are kept.
                    opcode_d = instruction[31:24];
                    tgt_d    = instruction[16 +: IDX_W];
                    data_d   = instruction[GS_WIDTH-1:0];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode_q)
                    8'h01:   state_d = ST_LOAD;
                    8'h02:   state_d = ST_CLEAR;
                    8'h04:   state_d = ST_SHIFT_SETUP;
                    8'h08:   state_d = ST_GSCFG;
                    default: state_d = ST_WAIT;
                endcase
            end
            ST_LOAD: begin
                chbuf_d[tgt_q] = data_q;
                state_d        = ST_WAIT;
            end
            ST_CLEAR: begin
                for (int i = 0; i < NUM_CH; i++) chbuf_d[i] = '0;
                state_d = ST_WAIT;
            end
            ST_SHIFT_SETUP: begin
                // Highest channel lands in the MSBs so it leaves first.
                for (int i = 0; i < NUM_CH; i++) shreg_d[i*GS_WIDTH +: GS_WIDTH] = chbuf_q[i];
                cnt_d   = CNT_W'(SHIFT_LEN);
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                shreg_d = {shreg_q[SHIFT_LEN-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? ST_LATCH : ST_SHIFT_LO;
            end
            ST_LATCH: begin
                state_d = ST_WAIT;
            end
            ST_GSCFG: begin
                gs_en_d = data_q[0];
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (instruction == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so the registered copies
        // line up with the state code they belong to.
        serial_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? shreg_d[SHIFT_LEN-1] : 1'b0;
        sclk_d   = (state_d == ST_SHIFT_HI);
        lat_d    = (state_d == ST_LATCH) ? (4'b0001 << tgt_q[1:0]) : 4'b0000;
        gsclk_d  = gs_en_q ? ~gsclk_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            tgt_q    <= '0;
            data_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) chbuf_q[i] <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            gs_en_q  <= 1'b0;
            serial_q <= 1'b0;
            sclk_q   <= 1'b0;
            lat_q    <= 4'b0000;
            gsclk_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            tgt_q    <= tgt_d;
            data_q   <= data_d;
            chbuf_q  <= chbuf_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            gs_en_q  <= gs_en_d;
            serial_q <= serial_d;
            sclk_q   <= sclk_d;
            lat_q    <= lat_d;
            gsclk_q  <= gsclk_d;
        end
    end

    assign state  = state_q;
    assign serial = serial_q;
    assign sclk   = sclk_q;
    assign lat    = lat_q;
    assign gsclk  = gsclk_q;

endmodule

// File: tb/tb_controller.sv
// ----------------------------------------------------------------------------
// tb_controller
// Drives directed and random command transactions into controller and checks
// them against a transaction-level model of the channel buffer and gsclk
// enable: shifted bit streams, latch strobes, dispatch targets, single
// execution of held commands, gsclk behaviour and reset.
// ----------------------------------------------------------------------------
module tb_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        serial;
    logic        sclk;
    logic [3:0]  lat;
    logic        gsclk;
    logic [3:0]  state;

    int n_chk  = 0;
    int n_fail = 0;

    int mbuf [16];
    bit m_gs_en;

    controller #(.NUM_CH(16), .GS_WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .serial     (serial),
        .sclk       (sclk),
        .lat        (lat),
        .gsclk      (gsclk),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_after_decode(input logic [7:0] op);
        case (op)
            8'h01:   return 2;
            8'h02:   return 3;
            8'h04:   return 4;
            8'h08:   return 8;
            default: return 9;
        endcase
    endfunction

    task automatic model_apply(input logic [7:0] op, input logic [7:0] tgt, input logic [15:0] dat);
        case (op)
            8'h01: mbuf[tgt[3:0]] = int'(dat[11:0]);
            8'h02: for (int i = 0; i < 16; i++) mbuf[i] = 0;
            8'h08: m_gs_en = dat[0];
            default: ;
        endcase
    endtask

    // One command: apply for 'hold' edges, release, wait for return to IDLE.
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] tgt, input logic [15:0] dat, input int hold);
        int  cyc, dec_cyc, edges, lat_cyc, shift_cyc, bad, bit_err;
        int  after_dec;
        logic [3:0] lat_val;
        bit  prev_dec, prev_sclk, done;
        bit  got_bits [192];
        cyc = 0; dec_cyc = 0; edges = 0; lat_cyc = 0; shift_cyc = 0; bad = 0; bit_err = 0;
        after_dec = -1; lat_val = 4'b0; prev_dec = 0; prev_sclk = 0; done = 0;
        instruction = {op, tgt, dat};
        while (cyc < 2000 && !done) begin
            tick();
            cyc++;
            if (prev_dec) after_dec = int'(state);
            prev_dec = (state == 4'd1);
            if (state == 4'd1) dec_cyc++;
            if (sclk && !prev_sclk) begin
                if (edges < 192) got_bits[edges] = serial;
                edges++;
            end
            prev_sclk = sclk;
            if (lat != 4'b0) begin
                lat_cyc++;
                lat_val = lat;
            end
            if (state == 4'd5 || state == 4'd6) shift_cyc++;
            if (sclk && !(state == 4'd5 || state == 4'd6)) bad++;
            if (serial && !(state == 4'd5 || state == 4'd6 || state == 4'd7)) bad++;
            if (lat != 4'b0 && state != 4'd7) bad++;
            if (cyc > hold && state == 4'd0) done = 1;
            if (cyc == hold) instruction = 32'h0;
        end
        instruction = 32'h0;
        check("timeout", 32'(done), 32'd1);
        check("decode_once", 32'(dec_cyc), 32'd1);
        check("dispatch", 32'(after_dec), 32'(exp_after_decode(op)));
        check("idle_outputs", 32'(bad), 32'd0);
        if (op == 8'h04) begin
            for (int k = 0; k < 192; k++) begin
                if (got_bits[k] != bit'((mbuf[15 - k / 12] >> (11 - k % 12)) & 1)) bit_err++;
            end
            check("sclk_edges", 32'(edges), 32'd192);
            check("shift_cycles", 32'(shift_cyc), 32'd384);
            check("shift_bits", 32'(bit_err), 32'd0);
            check("lat_cycles", 32'(lat_cyc), 32'd1);
            check("lat_value", 32'(lat_val), 32'(1 << tgt[1:0]));
        end else begin
            check("no_sclk", 32'(edges), 32'd0);
            check("no_lat", 32'(lat_cyc), 32'd0);
        end
        model_apply(op, tgt, dat);
    endtask

    task automatic check_gs();
        int  toggles, ones;
        logic prev;
        toggles = 0; ones = 0;
        tick();
        prev = gsclk;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gsclk != prev) toggles++;
            if (gsclk) ones++;
            prev = gsclk;
        end
        if (m_gs_en) check("gs_toggle", 32'(toggles), 32'd6);
        else         check("gs_off", 32'(ones), 32'd0);
    endtask

    initial begin
        logic [7:0]  op, tgt;
        logic [15:0] dat;
        int          sel, hold, lat_seen;

        for (int i = 0; i < 16; i++) mbuf[i] = 0;
        m_gs_en     = 0;
        rst         = 1'b1;
        instruction = 32'h0;
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", {26'd0, serial, sclk, lat, gsclk}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_state", 32'(state), 32'd0);
            check("idle_outs", {26'd0, serial, sclk, lat, gsclk}, 32'd0);
        end

        // Channel 3 = 0xABC, then shift to chain 1.
        do_cmd(8'h01, 8'h03, 16'h0ABC, 3);
        do_cmd(8'h04, 8'h01, 16'h0000, 4);
        // Shift of a cleared buffer.
        do_cmd(8'h02, 8'h00, 16'h0000, 2);
        do_cmd(8'h04, 8'h01, 16'h0000, 4);
        // gsclk enable then disable.
        do_cmd(8'h08, 8'h00, 16'h0001, 2);
        check_gs();
        do_cmd(8'h08, 8'h00, 16'h0000, 2);
        check_gs();
        // Unknown opcode held for a while.
        do_cmd(8'h55, 8'h00, 16'h0000, 10);

        // Reset in the middle of a shift.
        do_cmd(8'h01, 8'h0F, 16'hFFFF, 2);
        do_cmd(8'h08, 8'h00, 16'h0001, 2);
        instruction = 32'h0402_0000;
        repeat (4) tick();
        instruction = 32'h0;
        repeat (60) tick();
        check("midshift_state", 32'(state), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_outs", {26'd0, serial, sclk, lat, gsclk}, 32'd0);
        lat_seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (lat != 4'b0 || state != 4'd0) lat_seen++;
        end
        check("abort_quiet", 32'(lat_seen), 32'd0);
        for (int i = 0; i < 16; i++) mbuf[i] = 0;
        m_gs_en = 0;
        check_gs();
        do_cmd(8'h04, 8'h02, 16'h0000, 3);

        // Random command mix.
        for (int t = 0; t < 30; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)       op = 8'h01;
            else if (sel == 3) op = 8'h02;
            else if (sel < 6)  op = 8'h04;
            else if (sel == 6) op = 8'h08;
            else               op = 8'($urandom_range(0, 255));
            tgt  = 8'($urandom);
            dat  = 16'($urandom);
            if ({op, tgt, dat} == 32'h0) dat = 16'h0001;
            hold = int'($urandom_range(1, 12));
            do_cmd(op, tgt, dat, hold);
            check_gs();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
